// File: rtl/wait_state_ram.sv
// wait_state_ram: byte-addressed big-endian data memory with programmable wait states and an enable/mfc handshake.
// Optional alignment check enabled by defining RAM_ALIGN_CHECK_EN.
`default_nettype none

module wait_state_ram #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  read_write,
    input  logic                  sig,
    input  logic [1:0]            data_length,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  mfc,
    output logic                  busy,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic                  accept, access;

    logic                  rw_q, sig_q;
    logic [1:0]            len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;

    reg [7:0] memory [0:DEPTH-1];

    // Offsets wrap naturally in ADDR_WIDTH-bit arithmetic.
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);

    logic misalign, reject;
`ifdef RAM_ALIGN_CHECK_EN
    assign misalign = ((len_q == 2'b01) && addr_q[0]) ||
                      ((len_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign reject = (len_q == 2'b11) || misalign;

    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata;
    assign b0 = memory[addr_q];
    assign b1 = memory[a1];
    assign b2 = memory[a2];
    assign b3 = memory[a3];

    always_comb begin
        rdata = 32'b0;
        case (len_q)
            2'b00:   rdata = {{24{sig_q & b0[7]}}, b0};
            2'b01:   rdata = {{16{sig_q & b0[7]}}, b0, b1};
            2'b10:   rdata = {b0, b1, b2, b3};
            default: rdata = 32'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_W'(WAIT_CYCLES);
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    access   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!enable) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rw_q     <= 1'b0;
            sig_q    <= 1'b0;
            len_q    <= 2'b00;
            addr_q   <= '0;
            din_q    <= 32'b0;
            data_out <= 32'b0;
            mfc      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                rw_q   <= read_write;
                sig_q  <= sig;
                len_q  <= data_length;
                addr_q <= address;
                din_q  <= data_in;
            end
            if (access) begin
                mfc <= 1'b1;
                err <= reject;
                if (!reject && rw_q) data_out <= rdata;
            end
            if ((state == S_DONE) && !enable) begin
                mfc <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; a reset before the access cycle leaves it untouched.
    always_ff @(posedge clk) begin
        if (access && !reject && !rw_q) begin
            case (len_q)
                2'b00: memory[addr_q] <= din_q[7:0];
                2'b01: begin
                    memory[addr_q] <= din_q[15:8];
                    memory[a1]     <= din_q[7:0];
                end
                2'b10: begin
                    memory[addr_q] <= din_q[31:24];
                    memory[a1]     <= din_q[23:16];
                    memory[a2]     <= din_q[15:8];
                    memory[a3]     <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wait_state_ram.sv
// Scoreboard bench for wait_state_ram: directed requests push expected {err,data}; a monitor checks on each mfc rise.
`default_nettype none

module tb_wait_state_ram;

    localparam int AW = 9;
    localparam int WC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, enable, read_write, sig;
    logic [1:0]    data_length;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic [31:0]   data_out, data_out0, data_out3;
    logic          mfc, busy, err;
    logic          en0, mfc0, busy0, err0;
    logic          en3, mfc3, busy3, err3;

    wait_state_ram #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .read_write(read_write), .sig(sig),
        .data_length(data_length), .address(address), .data_in(data_in),
        .data_out(data_out), .mfc(mfc), .busy(busy), .err(err)
    );

    wait_state_ram #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(en0), .read_write(read_write), .sig(sig),
        .data_length(data_length), .address(address), .data_in(data_in),
        .data_out(data_out0), .mfc(mfc0), .busy(busy0), .err(err0)
    );

    wait_state_ram #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(en3), .read_write(read_write), .sig(sig),
        .data_length(data_length), .address(address), .data_in(data_in),
        .data_out(data_out3), .mfc(mfc3), .busy(busy3), .err(err3)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] last_rd;
    logic        mfc_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mfc && !mfc_d) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mon_unexpected_mfc: got mfc=1 expected no completion");
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_data", data_out, mon_e[31:0]);
                check("mon_err", {31'b0, err}, {31'b0, mon_e[32]});
            end
        end
        mfc_d = mfc;
    end

    // One full handshake; inputs are scrambled once accepted to show the latched copy is used.
    task automatic req(input logic rw, input logic sg, input logic [1:0] len, input logic [AW-1:0] a,
                       input logic [31:0] din, input logic [31:0] exp_d, input logic exp_e,
                       input int hold, input string name);
        int n;
        @(negedge clk);
        read_write = rw; sig = sg; data_length = len; address = a; data_in = din; enable = 1'b1;
        exp_q.push_back({exp_e, exp_d});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                read_write = ~rw; sig = ~sg; data_length = ~len; address = ~a; data_in = ~din;
            end
        end while (!mfc && n < 40);
        check({name, "_latency"}, 32'(n), 32'(WC + 2));
        repeat (hold) begin
            @(negedge clk);
            check({name, "_mfc_hold"}, {31'b0, mfc}, 32'd1);
        end
        enable = 1'b0;
        @(negedge clk);
        check({name, "_mfc_fall"}, {30'b0, mfc, busy}, 32'd0);
    endtask

    initial begin
        int n, pulses;
        reset_n = 1'b0; enable = 1'b0; en0 = 1'b0; en3 = 1'b0;
        read_write = 1'b0; sig = 1'b0; data_length = 2'b00; address = '0; data_in = 32'b0;
        dut.memory[0] = 8'h80; dut.memory[1] = 8'h01; dut.memory[2] = 8'h02; dut.memory[3] = 8'h03;
        dut.memory[4] = 8'h00; dut.memory[5] = 8'h00; dut.memory[6] = 8'h66; dut.memory[7] = 8'h77;
        dut.memory[510] = 8'h00; dut.memory[511] = 8'h00;
        dut0.memory[0] = 8'h80; dut0.memory[1] = 8'h01; dut0.memory[2] = 8'h02; dut0.memory[3] = 8'h03;
        dut3.memory[0] = 8'h80; dut3.memory[1] = 8'h01; dut3.memory[2] = 8'h02; dut3.memory[3] = 8'h03;

        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 32'h0);
        check("rst_flags", {29'b0, mfc, busy, err}, 32'h0);
        reset_n = 1'b1;

        req(1'b1, 1'b0, 2'b10, 9'd0, 32'h0, 32'h80010203, 1'b0, 0, "rd_word0");
        req(1'b1, 1'b1, 2'b00, 9'd0, 32'h0, 32'hFFFFFF80, 1'b0, 0, "rd_byte_s");
        req(1'b1, 1'b0, 2'b00, 9'd0, 32'h0, 32'h00000080, 1'b0, 0, "rd_byte_u");
        last_rd = 32'h00000080;
        req(1'b0, 1'b0, 2'b01, 9'd4, 32'h12340800, last_rd, 1'b0, 0, "wr_half4");
        check("mem4", {24'b0, dut.memory[4]}, 32'h08);
        check("mem5", {24'b0, dut.memory[5]}, 32'h00);
        req(1'b1, 1'b0, 2'b01, 9'd4, 32'h0, 32'h00000800, 1'b0, 0, "rd_half4");
        req(1'b1, 1'b1, 2'b01, 9'd0, 32'h0, 32'hFFFF8001, 1'b0, 0, "rd_half0_s");
        last_rd = 32'hFFFF8001;

`ifdef RAM_ALIGN_CHECK_EN
        req(1'b0, 1'b0, 2'b10, 9'd510, 32'hDEADBEEF, last_rd, 1'b1, 0, "wr_word_wrap");
        check("wrap_mem510", {24'b0, dut.memory[510]}, 32'h00);
        check("wrap_mem511", {24'b0, dut.memory[511]}, 32'h00);
        check("wrap_mem0", {24'b0, dut.memory[0]}, 32'h80);
        check("wrap_mem1", {24'b0, dut.memory[1]}, 32'h01);
        req(1'b1, 1'b0, 2'b10, 9'd510, 32'h0, last_rd, 1'b1, 0, "rd_word_wrap");
`else
        req(1'b0, 1'b0, 2'b10, 9'd510, 32'hDEADBEEF, last_rd, 1'b0, 0, "wr_word_wrap");
        check("wrap_mem510", {24'b0, dut.memory[510]}, 32'hDE);
        check("wrap_mem511", {24'b0, dut.memory[511]}, 32'hAD);
        check("wrap_mem0", {24'b0, dut.memory[0]}, 32'hBE);
        check("wrap_mem1", {24'b0, dut.memory[1]}, 32'hEF);
        req(1'b1, 1'b0, 2'b10, 9'd510, 32'h0, 32'hDEADBEEF, 1'b0, 0, "rd_word_wrap");
        last_rd = 32'hDEADBEEF;
`endif

        req(1'b1, 1'b1, 2'b11, 9'd0, 32'h0, last_rd, 1'b1, 5, "reserved");

        // enable withdrawn during WAIT: access still completes, mfc lasts one cycle
        @(negedge clk);
        read_write = 1'b1; sig = 1'b0; data_length = 2'b10; address = 9'd4; enable = 1'b1;
        exp_q.push_back({1'b0, 32'h08006677});
        @(negedge clk);
        enable = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (mfc) pulses++;
        end
        check("drop_enable_pulse", 32'(pulses), 32'd1);
        check("drop_enable_busy", {31'b0, busy}, 32'd0);

        // reset while a byte write is still waiting
        @(negedge clk);
        read_write = 1'b0; data_length = 2'b00; address = 9'd7; data_in = 32'h000000AA; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midwait_rst_data", data_out, 32'h0);
        check("midwait_rst_flags", {29'b0, mfc, busy, err}, 32'h0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait_mem7", {24'b0, dut.memory[7]}, 32'h77);
        reset_n = 1'b1;
        req(1'b1, 1'b0, 2'b00, 9'd7, 32'h0, 32'h00000077, 1'b0, 0, "rd_byte7");

        // latency sweep on the WAIT_CYCLES = 0 and 3 instances
        @(negedge clk);
        read_write = 1'b1; sig = 1'b0; data_length = 2'b10; address = 9'd0; en0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mfc0 && n < 40);
        check("wc0_latency", 32'(n), 32'd2);
        check("wc0_data", data_out0, 32'h80010203);
        en0 = 1'b0;
        @(negedge clk);
        check("wc0_mfc_fall", {31'b0, mfc0}, 32'd0);

        @(negedge clk);
        read_write = 1'b1; sig = 1'b0; data_length = 2'b10; address = 9'd0; en3 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mfc3 && n < 40);
        check("wc3_latency", 32'(n), 32'd5);
        check("wc3_data", data_out3, 32'h80010203);
        en3 = 1'b0;
        @(negedge clk);
        check("wc3_mfc_fall", {31'b0, mfc3}, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
